// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration responder.
// Address map, FSM state encoding and the STATUS word packing.
package fll_cfg_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned MULT_W = 16;

    localparam logic [ADDR_W-1:0] FLL_ADDR_STATUS = 2'd0;
    localparam logic [ADDR_W-1:0] FLL_ADDR_CFG1   = 2'd1;
    localparam logic [ADDR_W-1:0] FLL_ADDR_CFG2   = 2'd2;
    localparam logic [ADDR_W-1:0] FLL_ADDR_INTEG  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } fll_cfg_state_e;

    // Handshake payload, stable while the request level is high
    typedef struct packed {
        logic              wrn;
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] data;
    } fll_cfg_cmd_t;

    function automatic logic [DATA_W-1:0] pack_status(input logic lock, input logic [MULT_W-1:0] mult);
        return {lock, 15'b0, mult};
    endfunction

endpackage

// File: rtl/fll_cfg_sync.sv
// Level synchroniser: SYNC_STAGES flops in series, cleared by async reset.
// Shared with the bridge-side ack/lock synchronisers.
module fll_cfg_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/fll_cfg_responder.sv
// FLL-side end of the 4-phase configuration handshake: one register access
// per request on a 4-entry register file, acknowledged with a registered level.
module fll_cfg_responder
    import fll_cfg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] CFG1_RST    = 32'h0000_0000,
    parameter logic [31:0] CFG2_RST    = 32'h0000_0000,
    parameter logic [31:0] INTEG_RST   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cfg_req,
    input  logic        cfg_wrn,
    input  logic [1:0]  cfg_add,
    input  logic [31:0] cfg_data,
    output logic        cfg_ack,
    output logic [31:0] cfg_r_data,
    input  logic        fll_lock_i,
    input  logic [15:0] fll_mult_i,
    output logic [31:0] cfg1_o,
    output logic [31:0] cfg2_o,
    output logic [31:0] integ_o,
    output logic        integ_wr_o
);

    fll_cfg_state_e    state_q;
    fll_cfg_state_e    state_d;
    fll_cfg_cmd_t      cmd;
    logic              req_s;
    logic              ack_d_c;
    logic              wr_c;
    logic              rd_c;
    logic [DATA_W-1:0] rd_mux_c;

    assign cmd = '{wrn: cfg_wrn, add: cfg_add, data: cfg_data};

    fll_cfg_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk  (HCLK),
        .rst_n(HRESETn),
        .d    (cfg_req),
        .q    (req_s)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_s) state_d = ST_ACCESS;
            ST_ACCESS:  state_d = ST_ACK;
            ST_ACK:     if (!req_s) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Register updates land on the edge entering ACCESS, so the new contents
    // and the INTEG write strobe are visible during the ACCESS cycle itself.
    always_comb begin
        ack_d_c = 1'b0;
        wr_c    = 1'b0;
        rd_c    = 1'b0;
        if (state_d == ST_ACK) ack_d_c = 1'b1;
        if (state_d == ST_ACCESS) begin
            wr_c = !cmd.wrn;
            rd_c = cmd.wrn;
        end
    end

    always_comb begin
        case (cmd.add)
            FLL_ADDR_CFG1:  rd_mux_c = cfg1_o;
            FLL_ADDR_CFG2:  rd_mux_c = cfg2_o;
            FLL_ADDR_INTEG: rd_mux_c = integ_o;
            default:        rd_mux_c = pack_status(fll_lock_i, fll_mult_i);
        endcase
    end

    // STATUS is read-only: a write to it falls through the default arm
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cfg_ack    <= 1'b0;
            cfg_r_data <= '0;
            cfg1_o     <= CFG1_RST;
            cfg2_o     <= CFG2_RST;
            integ_o    <= INTEG_RST;
            integ_wr_o <= 1'b0;
        end else begin
            cfg_ack    <= ack_d_c;
            integ_wr_o <= wr_c && (cmd.add == FLL_ADDR_INTEG);
            if (rd_c) begin
                cfg_r_data <= rd_mux_c;
            end
            if (wr_c) begin
                case (cmd.add)
                    FLL_ADDR_CFG1:  cfg1_o  <= cmd.data;
                    FLL_ADDR_CFG2:  cfg2_o  <= cmd.data;
                    FLL_ADDR_INTEG: integ_o <= cmd.data;
                    default:        ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Scoreboard bench for fll_cfg_responder: the driver pushes the expected
// post-access register state, a monitor checks it on every cfg_ack rise.
module tb_fll_cfg_responder;
    import fll_cfg_pkg::*;

    localparam logic [31:0] T_CFG1_RST  = 32'h1111_0001;
    localparam logic [31:0] T_CFG2_RST  = 32'h2222_0002;
    localparam logic [31:0] T_INTEG_RST = 32'h3333_0003;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] cfg1;
        logic [31:0] cfg2;
        logic [31:0] integ;
        int          pulses;
    } exp_t;

    logic        HCLK;
    logic        HRESETn;
    logic        cfg_req;
    logic        cfg_wrn;
    logic [1:0]  cfg_add;
    logic [31:0] cfg_data;
    logic        cfg_ack;
    logic [31:0] cfg_r_data;
    logic        fll_lock_i;
    logic [15:0] fll_mult_i;
    logic [31:0] cfg1_o;
    logic [31:0] cfg2_o;
    logic [31:0] integ_o;
    logic        integ_wr_o;

    int          n_checks;
    int          n_pass;
    exp_t        sb[$];
    logic [31:0] m_rdata;
    logic [31:0] m_cfg1;
    logic [31:0] m_cfg2;
    logic [31:0] m_integ;

    fll_cfg_responder #(
        .SYNC_STAGES(2),
        .CFG1_RST   (T_CFG1_RST),
        .CFG2_RST   (T_CFG2_RST),
        .INTEG_RST  (T_INTEG_RST)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cfg_req   (cfg_req),
        .cfg_wrn   (cfg_wrn),
        .cfg_add   (cfg_add),
        .cfg_data  (cfg_data),
        .cfg_ack   (cfg_ack),
        .cfg_r_data(cfg_r_data),
        .fll_lock_i(fll_lock_i),
        .fll_mult_i(fll_mult_i),
        .cfg1_o    (cfg1_o),
        .cfg2_o    (cfg2_o),
        .integ_o   (integ_o),
        .integ_wr_o(integ_wr_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_rdata = 32'h0;
        m_cfg1  = T_CFG1_RST;
        m_cfg2  = T_CFG2_RST;
        m_integ = T_INTEG_RST;
    endtask

    // Apply one access to the model and queue the expected outcome
    task automatic push_expect(input logic wrn, input logic [1:0] add, input logic [31:0] data);
        exp_t e;
        e.pulses = 0;
        if (wrn) begin
            case (add)
                2'd1:    m_rdata = m_cfg1;
                2'd2:    m_rdata = m_cfg2;
                2'd3:    m_rdata = m_integ;
                default: m_rdata = {fll_lock_i, 15'b0, fll_mult_i};
            endcase
        end else begin
            case (add)
                2'd1:    m_cfg1 = data;
                2'd2:    m_cfg2 = data;
                2'd3:    begin m_integ = data; e.pulses = 1; end
                default: ;
            endcase
        end
        e.rdata = m_rdata;
        e.cfg1  = m_cfg1;
        e.cfg2  = m_cfg2;
        e.integ = m_integ;
        sb.push_back(e);
    endtask

    task automatic start_txn(input logic wrn, input logic [1:0] add, input logic [31:0] data);
        int n;
        push_expect(wrn, add, data);
        cfg_wrn  = wrn;
        cfg_add  = add;
        cfg_data = data;
        cfg_req  = 1'b1;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!cfg_ack && n < 20);
        check("ack_latency", 32'(n), 32'd4);
    endtask

    task automatic finish_txn(input int gap);
        int n;
        repeat (2) @(negedge HCLK);
        check("ack_hold", {31'b0, cfg_ack}, 32'd1);
        cfg_req = 1'b0;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (cfg_ack && n < 20);
        check("release_latency", 32'(n), 32'd3);
        check("rdata_held", cfg_r_data, m_rdata);
        repeat (gap) @(negedge HCLK);
    endtask

    task automatic txn(input logic wrn, input logic [1:0] add, input logic [31:0] data, input int gap);
        start_txn(wrn, add, data);
        finish_txn(gap);
    endtask

    // Request dropped right after it reached the synchroniser output
    task automatic early_drop_write(input logic [1:0] add, input logic [31:0] data);
        int n;
        int width;
        push_expect(1'b0, add, data);
        cfg_wrn  = 1'b0;
        cfg_add  = add;
        cfg_data = data;
        cfg_req  = 1'b1;
        repeat (2) @(negedge HCLK);
        cfg_req = 1'b0;
        n = 0;
        while (!cfg_ack && n < 20) begin
            @(negedge HCLK);
            n++;
        end
        width = 0;
        while (cfg_ack && width < 20) begin
            @(negedge HCLK);
            width++;
        end
        check("early_drop_ack_width", 32'(width), 32'd1);
        repeat (3) @(negedge HCLK);
    endtask

    // Scoreboard monitor: compare on every cfg_ack rise
    initial begin
        logic ack_prev;
        int   pulse_cnt;
        exp_t e;
        ack_prev  = 1'b0;
        pulse_cnt = 0;
        forever begin
            @(negedge HCLK);
            if (integ_wr_o) pulse_cnt++;
            if (cfg_ack && !ack_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_ack: got ack with empty queue expected none");
                end else begin
                    e = sb.pop_front();
                    check("sb_rdata", cfg_r_data, e.rdata);
                    check("sb_cfg1", cfg1_o, e.cfg1);
                    check("sb_cfg2", cfg2_o, e.cfg2);
                    check("sb_integ", integ_o, e.integ);
                    check("sb_integ_wr_pulses", 32'(pulse_cnt), 32'(e.pulses));
                end
                pulse_cnt = 0;
            end
            ack_prev = cfg_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        HRESETn    = 1'b0;
        cfg_req    = 1'b0;
        cfg_wrn    = 1'b0;
        cfg_add    = 2'd0;
        cfg_data   = 32'h0;
        fll_lock_i = 1'b1;
        fll_mult_i = 16'h05F5;
        model_reset();
        repeat (3) @(negedge HCLK);
        check("rst_ack", {31'b0, cfg_ack}, 32'd0);
        check("rst_rdata", cfg_r_data, 32'h0);
        check("rst_cfg1", cfg1_o, T_CFG1_RST);
        check("rst_cfg2", cfg2_o, T_CFG2_RST);
        check("rst_integ", integ_o, T_INTEG_RST);
        check("rst_integ_wr", {31'b0, integ_wr_o}, 32'd0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        txn(1'b0, FLL_ADDR_CFG1, 32'hDEAD_BEEF, 3);
        txn(1'b1, FLL_ADDR_CFG1, 32'h0, 3);
        txn(1'b1, FLL_ADDR_STATUS, 32'h0, 3);
        check("status_word", cfg_r_data, 32'h8000_05F5);
        txn(1'b0, FLL_ADDR_STATUS, 32'hFFFF_FFFF, 3);
        txn(1'b0, FLL_ADDR_INTEG, 32'h0000_1234, 3);
        txn(1'b0, FLL_ADDR_CFG2, 32'h0000_5678, 3);

        // Back-to-back: new request one cycle after ack falls
        txn(1'b0, FLL_ADDR_CFG1, 32'hCAFE_0001, 1);
        txn(1'b0, FLL_ADDR_INTEG, 32'h0000_00AB, 1);
        txn(1'b1, FLL_ADDR_CFG1, 32'h0, 1);
        txn(1'b1, FLL_ADDR_INTEG, 32'h0, 3);

        fll_lock_i = 1'b0;
        fll_mult_i = 16'h1234;
        txn(1'b1, FLL_ADDR_STATUS, 32'h0, 3);

        early_drop_write(FLL_ADDR_CFG2, 32'h0BAD_F00D);
        txn(1'b1, FLL_ADDR_CFG2, 32'h0, 3);

        // Reset while holding ACK after a CFG2 write
        start_txn(1'b0, FLL_ADDR_CFG2, 32'hA5A5_A5A5);
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_ack", {31'b0, cfg_ack}, 32'd0);
        check("midrst_cfg2", cfg2_o, T_CFG2_RST);
        check("midrst_cfg1", cfg1_o, T_CFG1_RST);
        check("midrst_rdata", cfg_r_data, 32'h0);
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        cfg_req = 1'b0;
        model_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        txn(1'b1, FLL_ADDR_CFG2, 32'h0, 3);
        txn(1'b0, FLL_ADDR_CFG1, 32'h0000_0042, 3);

        repeat (4) @(negedge HCLK);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
